// File: rtl/dlfloat_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_result_tx
// Purpose  : Buffers 16-bit DLFloat MAC results in a small circular FIFO and
//            serializes each word onto an 8-bit pad bus as two bytes using a
//            valid/ack handshake. Also drives the pad output enable.
// Ports    : clk, rst         - clock (rising edge), synchronous active-high reset
//            res_in/res_valid - result word push request
//            res_ready        - FIFO not full (push accepted when valid&&ready)
//            tx_data/tx_valid - byte presented to the pad bus
//            tx_ack           - consumer takes byte when tx_valid && tx_ack
//            tx_last          - second byte of a word is on the bus
//            tx_oe            - pad output enable, mirrors tx_valid
//            fifo_count       - words held in the FIFO (not the one in flight)
//            overflow         - sticky, set on a push attempt while full
// Revision : 1.0 - initial release
// ============================================================================
module dlfloat_result_tx #(
   parameter int DEPTH    = 4,
   parameter int HI_FIRST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              res_in,
   input  logic                     res_valid,
   output logic                     res_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ack,
   output logic                     tx_last,
   output logic                     tx_oe,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] c_full = DEPTH[CW-1:0];

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FIRST  = 2'd1,
      ST_SECOND = 2'd2
   } state_t;

   logic [15:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic [15:0]   r_hold;
   state_t        r_state;
   state_t        w_state_next;
   logic          w_push;
   logic          w_pop;
   logic          w_not_empty;
   logic [7:0]    w_byte_first;
   logic [7:0]    w_byte_second;

   assign w_not_empty = (r_count != '0);
   assign res_ready   = (r_count != c_full);
   // res_ready comes from the registered count, so a pop on a full-FIFO edge
   // cannot make room for a push on that same edge.
   assign w_push      = res_valid && res_ready;

   // ---------------------------------------------------------------------
   // Serializer next-state / pop decision
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_not_empty) begin
               w_pop        = 1'b1;
               w_state_next = ST_FIRST;
            end
         end
         ST_FIRST: begin
            if (tx_ack) begin
               w_state_next = ST_SECOND;
            end
         end
         ST_SECOND: begin
            if (tx_ack) begin
               // Back-to-back: reload hold directly without an idle cycle.
               if (w_not_empty) begin
                  w_pop        = 1'b1;
                  w_state_next = ST_FIRST;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FIFO storage (contents need no reset; pointers/count define validity)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[r_wr_ptr] <= res_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_hold     <= 16'h0000;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_hold   <= r_mem[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (res_valid && !res_ready) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: decoded purely from registers, so they stay stable while a
   // byte waits for tx_ack.
   // ---------------------------------------------------------------------
   assign w_byte_first  = (HI_FIRST != 0) ? r_hold[15:8] : r_hold[7:0];
   assign w_byte_second = (HI_FIRST != 0) ? r_hold[7:0]  : r_hold[15:8];

   always_comb begin
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      case (r_state)
         ST_FIRST: begin
            tx_data  = w_byte_first;
            tx_valid = 1'b1;
         end
         ST_SECOND: begin
            tx_data  = w_byte_second;
            tx_valid = 1'b1;
            tx_last  = 1'b1;
         end
         default: begin
            tx_data  = 8'h00;
         end
      endcase
   end

   assign tx_oe      = tx_valid;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire
